// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] DEFAULT_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - pipeline boundary register with load enable and clear-to-bubble
module if_id_register import fetch_pkg::*; #(
  parameter int                     ADDR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = DEFAULT_NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] d_instr,
  input  logic [ADDR_WIDTH-1:0]  d_pc,
  input  logic [ADDR_WIDTH-1:0]  d_pc_plus4,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [ADDR_WIDTH-1:0]  pc_plus4
);

  // A bubble only rewrites valid and the instruction word; the PC fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc       <= d_pc;
      pc_plus4 <= d_pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC owner and instruction-memory requester feeding decode
module instruction_fetch_stage import fetch_pkg::*; #(
  parameter int                     ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = DEFAULT_NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus4
);

  fetch_state_t           state, state_n;
  logic [ADDR_WIDTH-1:0]  pc, pc_n;
  logic [ADDR_WIDTH-1:0]  target, target_n;
  logic [INSTR_WIDTH-1:0] skid, skid_n;
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [ADDR_WIDTH-1:0]  redirect_aligned;
  logic                   out_load, out_clear;
  logic [INSTR_WIDTH-1:0] out_instr;

  assign pc_plus4         = pc + ADDR_WIDTH'(4);
  assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);

  assign imem_req  = !rst && (state == FETCH || state == DISCARD);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      target <= RESET_PC;
      skid   <= NOP_INSTR;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      target <= target_n;
      skid   <= skid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    target_n  = target;
    skid_n    = skid;
    out_load  = 1'b0;
    out_clear = 1'b0;
    out_instr = imem_rdata;

    if (redirect_valid) begin
      // A redirect always bubbles the output and abandons any skid word.
      out_clear = 1'b1;
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_n = redirect_aligned;
          end else begin
            target_n = redirect_aligned;
            state_n  = DISCARD;
          end
        end
        HOLD: begin
          pc_n    = redirect_aligned;
          state_n = FETCH;
        end
        DISCARD: begin
          if (imem_ready) begin
            pc_n    = redirect_aligned;
            state_n = FETCH;
          end else begin
            target_n = redirect_aligned;
          end
        end
        default: state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready && !stall) begin
            out_load = 1'b1;
            pc_n     = pc_plus4;
          end else if (imem_ready && stall) begin
            skid_n  = imem_rdata;
            state_n = HOLD;
          end else if (!stall) begin
            out_clear = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_load  = 1'b1;
            out_instr = skid;
            pc_n      = pc_plus4;
            state_n   = FETCH;
          end
        end
        DISCARD: begin
          // The stale request must still complete before the new target can be issued.
          out_clear = 1'b1;
          if (imem_ready) begin
            pc_n    = target;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  if_id_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (out_load),
    .clear      (out_clear),
    .d_instr    (out_instr),
    .d_pc       (pc),
    .d_pc_plus4 (pc_plus4),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .pc_plus4   (if_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_cmp = 0;
  int n_bad = 0;

  // Instructions the decode stage is owed, in program order: {instr, pc, pc+4}.
  logic [95:0] sb[$];

  // Architectural stream model: the next address whose word should reach decode.
  logic [31:0] fetch_ptr = RESET_PC;
  bit          discarding = 1'b0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  instruction_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: decode consumes whenever the output is valid and not stalled.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (if_valid && !stall) begin
        if (sb.size() == 0) begin
          chk("unexpected_instr", {if_instr, if_pc, if_pc_plus4}, 96'h0);
        end else begin
          logic [95:0] e;
          e = sb.pop_front();
          chk("delivered", {if_instr, if_pc, if_pc_plus4}, e);
        end
      end
      if (!if_valid) chk("bubble_instr", if_instr, NOP);
      if (redirect_valid) sb.delete();
    end
  end

  task automatic cyc(input bit r_v, input bit s, input bit rd, input bit rv, input logic [31:0] rp);
    bit hs;
    @(posedge clk);
    #3;
    if (prev_pend) chk("addr_stable", imem_addr, prev_addr);
    rst            = r_v;
    stall          = s;
    imem_ready     = rd;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    hs        = !r_v && imem_req && rd;
    prev_pend = !r_v && imem_req && !rd;
    prev_addr = imem_addr;
    if (r_v) begin
      fetch_ptr  = RESET_PC;
      discarding = 1'b0;
    end else if (rv) begin
      fetch_ptr  = {rp[31:2], 2'b00};
      discarding = imem_req && !rd;
    end else if (hs) begin
      if (discarding) begin
        discarding = 1'b0;
      end else begin
        chk("fetch_addr", imem_addr, fetch_ptr);
        sb.push_back({mem_word(imem_addr), imem_addr, imem_addr + 32'd4});
        fetch_ptr = fetch_ptr + 32'd4;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc_plus4, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);

    cyc(0, 0, 1, 0, 0);
    chk("req_after_rst", imem_req, 1'b1);
    chk("addr_0", imem_addr, 32'h0);
    cyc(0, 0, 1, 0, 0);
    chk("addr_4", imem_addr, 32'h4);
    chk("first_valid", if_valid, 1'b1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_pc4", if_pc_plus4, 32'h4);
    cyc(0, 1, 1, 0, 0);
    chk("addr_8", imem_addr, 32'h8);
    chk("pc_4", if_pc, 32'h4);
    cyc(0, 1, 1, 0, 0);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_pc", if_pc, 32'h4);
    cyc(0, 1, 1, 0, 0);
    chk("hold_req2", imem_req, 1'b0);
    chk("hold_valid", if_valid, 1'b1);
    cyc(0, 0, 1, 0, 0);
    chk("hold_pc3", if_pc, 32'h4);
    cyc(0, 0, 1, 0, 0);
    chk("skid_instr", if_instr, mem_word(32'h8));
    chk("skid_pc", if_pc, 32'h8);
    chk("resume_addr", imem_addr, 32'hC);

    cyc(0, 0, 0, 0, 0);
    chk("wait_addr1", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, 0);
    chk("wait_addr2", imem_addr, 32'h10);
    chk("wait_bubble1", if_valid, 1'b0);
    cyc(0, 0, 1, 0, 0);
    chk("wait_addr3", imem_addr, 32'h10);
    chk("wait_bubble2", if_valid, 1'b0);
    cyc(0, 0, 1, 0, 0);
    chk("wait_pc", if_pc, 32'h10);
    chk("wait_valid", if_valid, 1'b1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    cyc(0, 0, 0, 1, 32'h100);
    chk("disc_addr0", imem_addr, 32'h20);
    cyc(0, 0, 0, 0, 0);
    chk("disc_addr1", imem_addr, 32'h20);
    chk("disc_req", imem_req, 1'b1);
    chk("disc_bubble", if_valid, 1'b0);
    cyc(0, 0, 1, 0, 0);
    chk("disc_addr2", imem_addr, 32'h20);
    cyc(0, 1, 1, 0, 0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_bubble", if_valid, 1'b0);
    cyc(0, 1, 1, 1, 32'h103);
    chk("hold_redir_req", imem_req, 1'b0);
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("hold_redir_bubble", if_valid, 1'b0);
    chk("hold_redir_addr", imem_addr, 32'h100);
    cyc(0, 0, 1, 0, 0);
    chk("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(1, 0, 1, 0, 0);
    chk("midrst_req", imem_req, 1'b0);
    cyc(0, 0, 1, 0, 0);
    chk("midrst_valid", if_valid, 1'b0);
    chk("midrst_addr", imem_addr, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      bit r_v, s, rd, rv;
      logic [31:0] rp;
      r_v = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rp  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
      cyc(r_v, s, rd, rv, rp);
    end

    repeat (4) cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
